// File: rtl/nes_poll_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : nes_poll_ctrl                                                |
// | Description : NES-style serial gamepad sequencer with a byte-wide register |
// |               file. Drives pad latch/clock, samples serial data through a  |
// |               2-flop synchronizer and supports manual and periodic polls.  |
// |               Optional feature macro: NES_EDGE_DETECT_EN (adds EDGES at    |
// |               address 0x3, accumulated press events, W1C).                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module nes_poll_ctrl #(
   parameter int CLK_DIV  = 384,
   parameter int POLL_DIV = 1066667
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] address,
   input  logic [7:0] data_in,
   input  logic       data_write,
   output logic [7:0] data_out,
   output logic       user_interrupt,
   input  logic       nes_data,
   output logic       nes_latch,
   output logic       nes_clk
);

   localparam int TICK_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int POLL_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
   localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LATCH = 3'd1,
      S_PHI   = 3'd2,
      S_PLO   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [TICK_W-1:0]   tick_q;
   logic [POLL_W-1:0]   poll_q;
   logic                half_q, half_d;
   logic [2:0]          idx_q, idx_d;
   logic [7:0]          shift_q, shift_d;
   logic [7:0]          buttons_q;
   logic                auto_q;
   logic                new_q, new_d;
   logic                dropped_q, dropped_d;
   logic                latch_q, latch_d;
   logic                nclk_q, nclk_d;
   logic [1:0]          sync_q;
`ifdef NES_EDGE_DETECT_EN
   logic [7:0]          edges_q, edges_d;
`endif

   logic w_wr_ctrl;
   logic w_wr_stat;
   logic w_trig;
   logic w_poll_exp;
   logic w_tick_end;
   logic w_busy;
   logic w_done;
   logic w_sample;
   logic unused_bits;

   assign w_wr_ctrl  = data_write && (address == 4'h1);
   assign w_wr_stat  = data_write && (address == 4'h2);
   assign w_trig     = w_wr_ctrl && data_in[1];
   assign w_poll_exp = auto_q && (poll_q == POLL_LAST);
   assign w_tick_end = (tick_q == TICK_LAST);
   assign w_busy     = (state_q != S_IDLE);
   assign w_sample   = sync_q[1];
   assign unused_bits = ^data_in;

   // Two-flop synchronizer for the asynchronous pad data line
   always_ff @(posedge clk) begin
      if (rst) sync_q <= 2'b00;
      else     sync_q <= {sync_q[0], nes_data};
   end

   // Tick counter: runs only during a transaction, restarts from 0 each one
   always_ff @(posedge clk) begin
      if (rst || state_q == S_IDLE) tick_q <= '0;
      else if (w_tick_end)          tick_q <= '0;
      else                          tick_q <= tick_q + 1'b1;
   end

   // Poll timer: free-runs while AUTO is set, parked at 0 otherwise
   always_ff @(posedge clk) begin
      if (rst || !auto_q || w_poll_exp) poll_q <= '0;
      else                              poll_q <= poll_q + 1'b1;
   end

   // Sequencer state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         half_q  <= 1'b0;
         idx_q   <= 3'd0;
         shift_q <= 8'h00;
         latch_q <= 1'b0;
         nclk_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         half_q  <= half_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         latch_q <= latch_d;
         nclk_q  <= nclk_d;
      end
   end

   // Next-state logic; pad pins are registered from the next state
   always_comb begin
      state_d = state_q;
      half_d  = half_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      w_done  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_trig || w_poll_exp) begin
               state_d = S_LATCH;
               half_d  = 1'b0;
               idx_d   = 3'd0;
               shift_d = 8'h00;
            end
         end
         S_LATCH: begin
            if (w_tick_end) begin
               if (half_q) begin
                  shift_d[0] = w_sample;
                  idx_d      = 3'd1;
                  state_d    = S_PHI;
               end else begin
                  half_d = 1'b1;
               end
            end
         end
         S_PHI: begin
            if (w_tick_end) state_d = S_PLO;
         end
         S_PLO: begin
            if (w_tick_end) begin
               shift_d[idx_q] = w_sample;
               if (idx_q == 3'd7) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = S_PHI;
               end
            end
         end
         S_DONE: begin
            w_done  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      latch_d = (state_d == S_LATCH);
      nclk_d  = (state_d == S_PHI);
   end

   // Status flag next values: W1C clear first so a same-cycle set wins
   always_comb begin
      new_d     = new_q;
      dropped_d = dropped_q;
      if (w_wr_stat && data_in[1]) new_d     = 1'b0;
      if (w_wr_stat && data_in[2]) dropped_d = 1'b0;
      if (w_done)                  new_d     = 1'b1;
      if (w_poll_exp && w_busy)    dropped_d = 1'b1;
   end

   // Software-visible registers
   always_ff @(posedge clk) begin
      if (rst) begin
         auto_q    <= 1'b0;
         new_q     <= 1'b0;
         dropped_q <= 1'b0;
         buttons_q <= 8'h00;
      end else begin
         if (w_wr_ctrl) auto_q <= data_in[0];
         new_q     <= new_d;
         dropped_q <= dropped_d;
         if (w_done) buttons_q <= ~shift_q;
      end
   end

`ifdef NES_EDGE_DETECT_EN
   // Press-event accumulation: per-bit W1C with set priority
   always_comb begin
      edges_d = edges_q;
      if (data_write && (address == 4'h3)) edges_d = edges_d & ~data_in;
      if (w_done) edges_d = edges_d | (~shift_q & ~buttons_q);
   end

   // Edge register storage
   always_ff @(posedge clk) begin
      if (rst) edges_q <= 8'h00;
      else     edges_q <= edges_d;
   end
`endif

   // Combinational register read mux
   always_comb begin
      data_out = 8'h00;
      case (address)
         4'h0: data_out = buttons_q;
         4'h1: data_out = {7'd0, auto_q};
         4'h2: data_out = {5'd0, dropped_q, new_q, w_busy};
`ifdef NES_EDGE_DETECT_EN
         4'h3: data_out = edges_q;
`endif
         default: data_out = 8'h00;
      endcase
   end

   assign user_interrupt = new_q;
   assign nes_latch      = latch_q;
   assign nes_clk        = nclk_q;

endmodule

`default_nettype wire

// File: tb/tb_nes_poll_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_nes_poll_ctrl                                             |
// | Description : Self-checking bench for nes_poll_ctrl with a transaction-    |
// |               level reference model and a reactive shift-register pad.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_nes_poll_ctrl;

   localparam int CLK_DIV  = 4;
   localparam int POLL_DIV = 200;
   localparam int DONE_PH  = 16*CLK_DIV + 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] address = 4'h0;
   logic [7:0] data_in = 8'h00;
   logic       data_write = 1'b0;
   logic [7:0] data_out;
   logic       user_interrupt;
   logic       nes_data = 1'b1;
   logic       nes_latch;
   logic       nes_clk;

   nes_poll_ctrl #(.CLK_DIV(CLK_DIV), .POLL_DIV(POLL_DIV)) dut (
      .clk(clk), .rst(rst), .address(address), .data_in(data_in),
      .data_write(data_write), .data_out(data_out),
      .user_interrupt(user_interrupt), .nes_data(nes_data),
      .nes_latch(nes_latch), .nes_clk(nes_clk)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- pad model: 4021-style shift register ----------------
   logic [7:0] pad_word = 8'h00;
   int         pad_idx  = 0;
   logic       pad_prev = 1'b0;
   always @(negedge clk) begin
      if (nes_latch)                  pad_idx = 0;
      else if (nes_clk && !pad_prev)  pad_idx = pad_idx + 1;
      pad_prev = nes_clk;
      nes_data = (pad_idx < 8) ? ~pad_word[pad_idx] : 1'b0;
   end

   // ---------------- transaction-level reference model ----------------
   // m_phase = cycles since the start request (0 = idle)
   int         m_phase = 0;
   int         m_poll  = 0;
   logic       m_auto = 0, m_new = 0, m_drop = 0, m_valid = 0;
   logic [7:0] m_buttons = 0, m_edges = 0, m_word = 0;
   logic       t_pexp, t_trig, t_busy, t_done;

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_phase = 0; m_poll = 0; m_auto = 0; m_new = 0; m_drop = 0;
         m_buttons = 0; m_edges = 0; m_valid = 1;
      end else begin
         t_pexp = m_auto && (m_poll == POLL_DIV-1);
         t_trig = data_write && (address == 4'h1) && data_in[1];
         t_busy = (m_phase != 0);
         t_done = (m_phase == DONE_PH);
         if (data_write && address == 4'h2) begin
            if (data_in[1]) m_new  = 0;
            if (data_in[2]) m_drop = 0;
         end
         if (data_write && address == 4'h3) m_edges = m_edges & ~data_in;
         if (t_pexp && t_busy) m_drop = 1;
         if (t_done) begin
            m_edges   = m_edges | (m_word & ~m_buttons);
            m_buttons = m_word;
            m_new     = 1;
         end
         if (!t_busy) begin
            if (t_trig || t_pexp) begin m_phase = 1; m_word = pad_word; end
         end else if (t_done) m_phase = 0;
         else m_phase = m_phase + 1;
         if (!m_auto || t_pexp) m_poll = 0; else m_poll = m_poll + 1;
         if (data_write && address == 4'h1) m_auto = data_in[0];
      end
   end

   function automatic logic exp_latch(input int p);
      return (p >= 1) && (p <= 2*CLK_DIV);
   endfunction

   function automatic logic exp_clk(input int p);
      if (p <= 2*CLK_DIV || p > 16*CLK_DIV) return 1'b0;
      return (((p - 2*CLK_DIV - 1) / CLK_DIV) % 2) == 0;
   endfunction

   function automatic logic [7:0] exp_read(input logic [3:0] a);
      case (a)
         4'h0: return m_buttons;
         4'h1: return {7'd0, m_auto};
         4'h2: return {5'd0, m_drop, m_new, (m_phase != 0)};
`ifdef NES_EDGE_DETECT_EN
         4'h3: return m_edges;
`endif
         default: return 8'h00;
      endcase
   endfunction

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (m_valid) begin
         chk("nes_latch", {31'd0, nes_latch}, {31'd0, exp_latch(m_phase)});
         chk("nes_clk", {31'd0, nes_clk}, {31'd0, exp_clk(m_phase)});
         chk("user_interrupt", {31'd0, user_interrupt}, {31'd0, m_new});
         chk("data_out", {24'd0, data_out}, {24'd0, exp_read(address)});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      address = a; data_in = d; data_write = 1'b1;
      step();
      data_write = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] e);
      address = a; #1;
      chk(name, {24'd0, data_out}, {24'd0, e});
   endtask

   task automatic run_txn(input logic [7:0] w);
      pad_word = w;
      wr(4'h1, 8'h02);
      repeat (70) step();
   endtask

   int   lat_cnt, pulses, nr, w0;
   logic prevc, prevl, tw;
   int   rises[8];

   initial begin
      repeat (3) step();
      rst = 1'b0;
      rd_chk("reset_buttons", 4'h0, 8'h00);
      chk("reset_latch", {31'd0, nes_latch}, 32'd0);
      chk("reset_irq", {31'd0, user_interrupt}, 32'd0);

      // Reset in the middle of LATCH
      pad_word = 8'h09;
      wr(4'h1, 8'h02);
      repeat (3) step();
      rst = 1'b1; step(); step(); rst = 1'b0;
      chk("midrst_latch", {31'd0, nes_latch}, 32'd0);
      chk("midrst_clk", {31'd0, nes_clk}, 32'd0);
      rd_chk("midrst_buttons", 4'h0, 8'h00);
      rd_chk("midrst_status", 4'h2, 8'h00);
      lat_cnt = 0;
      for (int i = 0; i < 300; i++) begin step(); lat_cnt += nes_latch; end
      chk("idle_latch_cycles", lat_cnt, 0);

      // Manual read: A + Start pressed
      pad_word = 8'h09;
      wr(4'h1, 8'h02);
      address = 4'h0; #1;
      lat_cnt = 0; pulses = 0; prevc = 1'b0;
      for (int i = 1; i <= 66; i++) begin
         lat_cnt += nes_latch;
         if (nes_clk && !prevc) pulses++;
         prevc = nes_clk;
         if (i == 65) chk("irq_before_done", {31'd0, user_interrupt}, 32'd0);
         if (i == 66) begin
            chk("irq_at_66", {31'd0, user_interrupt}, 32'd1);
            chk("buttons_at_66", {24'd0, data_out}, 32'h09);
         end
         if (i != 66) step();
      end
      chk("latch_high_cycles", lat_cnt, 8);
      chk("clk_pulses", pulses, 7);
      rd_chk("status_after_read", 4'h2, 8'h02);

      // W1C clear, then clear colliding with DONE
      wr(4'h2, 8'h02);
      rd_chk("status_w1c", 4'h2, 8'h00);
      chk("irq_w1c", {31'd0, user_interrupt}, 32'd0);
      pad_word = 8'h5A;
      wr(4'h1, 8'h02);
      repeat (64) step();
      wr(4'h2, 8'h02);
      rd_chk("status_set_wins", 4'h2, 8'h02);
      rd_chk("buttons_5a", 4'h0, 8'h5A);

      // Auto-poll period, TRIG while busy, dropped poll
      pad_word = 8'hC3;
      w0 = cyc;
      wr(4'h1, 8'h01);
      address = 4'h2;
      nr = 0; prevl = 1'b0; tw = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (nes_latch && !prevl) begin
            if (nr < 8) rises[nr] = cyc;
            nr++;
         end
         prevl = nes_latch;
         if (cyc == w0 + 700) chk("dropped_clear", {31'd0, data_out[2]}, 32'd0);
         if (cyc == w0 + 850) chk("dropped_set", {31'd0, data_out[2]}, 32'd1);
         data_write = 1'b0;
         address    = 4'h2;
         if (nr == 1 && !tw && cyc == rises[0] + 20) begin
            address = 4'h1; data_in = 8'h03; data_write = 1'b1; tw = 1'b1;
         end
         if (cyc == w0 + 790) begin
            address = 4'h1; data_in = 8'h03; data_write = 1'b1;
         end
         step();
      end
      data_write = 1'b0;
      chk("rise_count", nr, 4);
      chk("first_rise", rises[0] - w0, 201);
      chk("period_1", rises[1] - rises[0], 200);
      chk("period_2", rises[2] - rises[1], 200);
      chk("manual_rise", rises[3] - w0, 791);
      wr(4'h1, 8'h00);
      repeat (80) step();

      // Press-event accumulation
      run_txn(8'h00);
      wr(4'h3, 8'hFF);
      run_txn(8'h01);
      run_txn(8'h03);
`ifdef NES_EDGE_DETECT_EN
      rd_chk("edges_acc", 4'h3, 8'h03);
      wr(4'h3, 8'h01);
      rd_chk("edges_w1c", 4'h3, 8'h02);
`else
      rd_chk("edges_absent", 4'h3, 8'h00);
      wr(4'h3, 8'h01);
      rd_chk("edges_absent_w", 4'h3, 8'h00);
`endif

      // Randomized traffic, checked every cycle by the model comparison
      for (int i = 0; i < 5000; i++) begin
         data_write = 1'b0;
         rst        = 1'b0;
         address    = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 29) == 0) begin
            address    = 4'($urandom_range(1, 3));
            data_in    = 8'($urandom);
            data_write = 1'b1;
         end
         if (m_phase == 0 && $urandom_range(0, 9) == 0) pad_word = 8'($urandom);
         if ($urandom_range(0, 1499) == 0) rst = 1'b1;
         step();
      end
      data_write = 1'b0;
      rst = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/nes_poll_ctrl.md
# nes_poll_ctrl

Sequencer for a NES-style serial gamepad behind a TinyQV byte peripheral slot. It drives the pad's latch and clock pins (uo_out[6] and uo_out[7] in the harness) and samples the pad's serial data line (ui_in[1]). The captured 8-bit button word is presented through a small byte-wide register file. It supports manual-triggered and periodic auto-poll transactions.

## Interface
Parameters:
- CLK_DIV, 384: system cycles per tick (one half NES-clock period; 6 µs at 64 MHz). Must be ≥ 4.
- POLL_DIV, 1066667: system cycles between auto-poll starts (60 Hz at 64 MHz). Must be > 16*CLK_DIV+2.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- address  in  4  register address
- data_in  in  8  write data
- data_write  in  1  one-cycle write strobe
- data_out  out  8  combinational read data for `address`
- user_interrupt  out  1  equals STATUS.NEW
- nes_data  in  1  pad serial data, asynchronous, active-low (0 = pressed)
- nes_latch  out  1  pad latch pulse, registered
- nes_clk  out  1  pad shift clock, registered

## Operation
Registers (unlisted addresses and bits read 0; writes to them are ignored):
- 0x0 BUTTONS (RO): last completed sample, 1 = pressed. Bits 0–7 are A, B, Select, Start, Up, Down, Left, Right.
- 0x1 CTRL (RW):
  - bit0 AUTO: enables the poll timer.
  - bit1 TRIG: write 1 to request a transaction; always reads 0.
- 0x2 STATUS:
  - bit0 BUSY (RO).
  - bit1 NEW: W1C, set on each completion.
  - bit2 DROPPED: W1C, set when a poll expiry occurs while BUSY.
  - If set and clear land in the same cycle, set wins.

Data path and timers:
- nes_data passes through a 2-flop synchronizer before use.
- Tick counter: counts 0..CLK_DIV-1 while not IDLE and is reset on leaving IDLE. A tick ends when the count equals CLK_DIV-1.
- Poll counter: counts 0..POLL_DIV-1 while AUTO=1 and expires at POLL_DIV-1. It is held at 0 while AUTO=0.

FSM states:
- IDLE: latch=0, clk=0, BUSY=0.
  - A start request is a TRIG write or a poll expiry.
  - On a start request, go to LATCH and clear the shift register and bit index.
- LATCH: latch=1 for 2 ticks.
  - At the end of the 2nd tick, sample bit0 and go to PHI with index=1.
- PHI: clk=1 for 1 tick, then go to PLO.
- PLO: clk=0 for 1 tick.
  - At its end, sample bit[index].
  - If index=7, go to DONE; otherwise increment index and go to PHI.
- DONE: one cycle.
  - BUTTONS ← ~shift.
  - Set NEW.
  - Go to IDLE.

Boundary rules:
- TRIG while BUSY is ignored and sets no flag.
- Poll expiry while BUSY sets DROPPED; no transaction is queued.
- TRIG and poll expiry in the same IDLE cycle start a single transaction.
- Clearing AUTO mid-transaction does not abort the transaction.
- Reset at any point returns to IDLE and clears all registers and counters. nes_latch, nes_clk, data_out (address 0), and user_interrupt all read 0 after reset.

## Timing
- A start request seen in IDLE at cycle T: nes_latch rises at T+1 and stays high for 2*CLK_DIV cycles.
- Seven nes_clk pulses follow, each CLK_DIV cycles high and CLK_DIV cycles low.
- DONE occurs at T+1+16*CLK_DIV. BUTTONS and NEW are visible at T+2+16*CLK_DIV, and BUSY falls in that same cycle.
- Sample points fall on the last cycle of each LATCH or PLO phase. nes_data must be stable from at least 3 cycles earlier, to cover the synchronizer.
- A register write takes effect on the cycle after data_write. data_out has zero-cycle read latency.

## Configuration
- NES_EDGE_DETECT_EN defined: adds register 0x3 EDGES (W1C, set wins).
  - At DONE, EDGES |= new_buttons & ~old_buttons, i.e. accumulated press events.
  - Reset value is 0x00.
- NES_EDGE_DETECT_EN undefined: address 0x3 reads 0 and no edge logic is built.

## Test plan
All scenarios use CLK_DIV=4, POLL_DIV=200.
- Reset:
  - Stimulus: assert rst for 2 cycles mid-LATCH.
  - Response: nes_latch=0, nes_clk=0, BUTTONS=0x00, STATUS=0x00 on the next cycle; nes_latch stays 0 for 300 cycles with AUTO=0.
- Manual read:
  - Stimulus: write CTRL=0x02 with the pad model returning pressed A and Start.
  - Response: latch high 8 cycles, 7 clk pulses, BUTTONS=0x09, NEW=1, user_interrupt=1 exactly 66 cycles after the write cycle.
- W1C clear:
  - Stimulus: write STATUS=0x02.
  - Response: NEW=0 and user_interrupt=0. Writing 0x02 in the DONE cycle leaves NEW=1.
- Auto-poll:
  - Stimulus: CTRL=0x01.
  - Response: latch rising edges exactly 200 cycles apart; a TRIG written while BUSY changes nothing.
- Dropped poll:
  - Stimulus: auto-poll running, TRIG issued 10 cycles before a poll expiry.
  - Response: DROPPED=1 and only one transaction in that window.
- Edge detect (NES_EDGE_DETECT_EN defined):
  - Stimulus: sample 0x01 then 0x03.
  - Response: EDGES=0x03. After writing 0x01, EDGES=0x02. With the macro undefined, address 0x3 reads 0x00.
